// File: rtl/ncc_peak_select.sv
// ncc_peak_select: tracks the maximum NCC score over one search strip and reports peak, position and match stats
module ncc_peak_select #(
  parameter int SCORE_W = 32,
  parameter int WIN_W   = 640,
  parameter int DESC_W  = 16,
  parameter int NUM_POS = WIN_W - DESC_W + 1,
  parameter int X_W     = $clog2(NUM_POS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic signed [SCORE_W-1:0] thresh,
  input  logic                      score_valid,
  output logic                      score_ready,
  input  logic signed [SCORE_W-1:0] score_data,
  input  logic                      score_last,
  output logic                      busy,
  output logic                      done,
  output logic signed [SCORE_W-1:0] best_score,
  output logic [X_W-1:0]            best_x,
  output logic                      peak_found,
  output logic [X_W:0]              above_cnt,
  output logic                      len_err
);
  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;
  state_t state, state_n;
  logic [X_W-1:0] xcnt, run_x, x_n;
  logic signed [SCORE_W-1:0] run_max, thr, max_n;
  logic [X_W:0] acnt, acnt_n;
  logic acc, gt, ge, at_end, fin;
  assign acc    = score_valid && score_ready;
  assign gt     = score_data > run_max;
  assign ge     = score_data >= thr;
  assign at_end = xcnt == X_W'(NUM_POS - 1);
  assign fin    = acc && !start && (score_last || at_end);
  assign max_n  = gt ? score_data : run_max;
  assign x_n    = gt ? xcnt : run_x;
  assign acnt_n = acnt + {{X_W{1'b0}}, ge && !(&acnt)};
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  // next state and handshake/status outputs; a start in SCAN restarts the strip in place
  always_comb begin
    state_n     = state;
    score_ready = state == SCAN;
    busy        = state == SCAN;
    done        = state == REPORT;
    case (state)
      IDLE:    state_n = start ? SCAN : IDLE;
      SCAN:    state_n = fin ? REPORT : SCAN;
      default: state_n = IDLE;
    endcase
  end
  // running max/count per beat; results are captured on the final beat so they are valid alongside done
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      xcnt       <= '0;
      run_x      <= '0;
      run_max    <= '0;
      thr        <= '0;
      acnt       <= '0;
      best_score <= '0;
      best_x     <= '0;
      peak_found <= 1'b0;
      above_cnt  <= '0;
      len_err    <= 1'b0;
    end else begin
      if (start && state != REPORT) begin
        xcnt    <= '0;
        run_x   <= '0;
        run_max <= {1'b1, {(SCORE_W-1){1'b0}}};
        acnt    <= '0;
        thr     <= thresh;
      end else if (acc) begin
        xcnt    <= xcnt + 1'b1;
        run_x   <= x_n;
        run_max <= max_n;
        acnt    <= acnt_n;
      end
      if (fin) begin
        best_score <= max_n;
        best_x     <= x_n;
        peak_found <= max_n >= thr;
        above_cnt  <= acnt_n;
        len_err    <= score_last != at_end;
      end
    end
endmodule

// File: tb/tb_ncc_peak_select.sv
// tb_ncc_peak_select: scoreboard bench for ncc_peak_select strip results and handshake timing
module tb_ncc_peak_select;
  logic clk = 0, rst = 1, start = 0, score_valid = 0, score_last = 0;
  logic signed [31:0] thresh = 0, score_data = 0;
  logic score_ready, busy, done, peak_found, len_err;
  logic signed [31:0] best_score;
  logic [9:0] best_x;
  logic [10:0] above_cnt;
  int checks = 0, failures = 0;
  logic signed [31:0] sc [0:639];
  typedef struct {
    logic signed [31:0] s;
    logic [9:0] x;
    logic pf;
    logic [10:0] ac;
    logic le;
  } exp_t;
  exp_t q[$];

  ncc_peak_select dut (
    .clk(clk), .rst(rst), .start(start), .thresh(thresh),
    .score_valid(score_valid), .score_ready(score_ready), .score_data(score_data),
    .score_last(score_last), .busy(busy), .done(done), .best_score(best_score),
    .best_x(best_x), .peak_found(peak_found), .above_cnt(above_cnt), .len_err(len_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int n, input int thr, input logic le);
    exp_t e;
    e.s = sc[0];
    e.x = 0;
    e.ac = 0;
    for (int i = 0; i < n; i++) begin
      if (sc[i] > e.s) begin
        e.s = sc[i];
        e.x = 10'(i);
      end
      if (sc[i] >= thr) e.ac++;
    end
    e.pf = e.s >= thr;
    e.le = le;
    return e;
  endfunction

  always @(negedge clk)
    if (done) begin
      if (q.size() == 0) check("spurious_done", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("best_score", best_score, e.s);
        check("best_x", 32'(best_x), 32'(e.x));
        check("peak_found", 32'(peak_found), 32'(e.pf));
        check("above_cnt", 32'(above_cnt), 32'(e.ac));
        check("len_err", 32'(len_err), 32'(e.le));
      end
    end

  task automatic begin_strip(input int t);
    score_valid = 0;
    start = 1;
    thresh = t;
    @(posedge clk); #1;
    start = 0;
    check("ready_after_start", 32'(score_ready), 1);
  endtask

  task automatic drive(input int n, input int last_idx, input int gap);
    int g, t;
    for (int i = 0; i < n; i++) begin
      g = gap == 2 ? 1 : gap == 1 ? int'($urandom_range(0, 1)) : 0;
      score_valid = 0;
      repeat (g) begin @(posedge clk); #1; end
      score_valid = 1;
      score_data = sc[i];
      score_last = i == last_idx;
      t = 0;
      while (!score_ready && t < 50) begin @(posedge clk); #1; t++; end
      if (t == 50) check("ready_timeout", 0, 1);
      @(posedge clk); #1;
    end
    score_valid = 0;
    score_last = 0;
  endtask

  task automatic ramp();
    for (int i = 0; i < 640; i++) sc[i] = i;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check("rst_ready", 32'(score_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_best_score", best_score, 0);
    check("rst_best_x", 32'(best_x), 0);
    check("rst_above", 32'(above_cnt), 0);
    check("rst_pf_le", {30'b0, peak_found, len_err}, 0);
    @(posedge clk); #1;
    ramp();
    begin_strip(600);
    check("busy_scan", 32'(busy), 1);
    q.push_back(model(625, 600, 0));
    drive(625, 624, 0);
    check("ramp_done_latency", 32'(done), 1);
    check("ramp_ready_low", 32'(score_ready), 0);
    check("ramp_best_x_const", 32'(best_x), 624);
    check("ramp_above_const", 32'(above_cnt), 25);
    @(posedge clk); #1;
    check("ramp_done_pulse", 32'(done), 0);
    for (int i = 0; i < 640; i++) sc[i] = -5;
    sc[100] = -1;
    sc[300] = -1;
    begin_strip(0);
    q.push_back(model(625, 0, 0));
    drive(625, 624, 0);
    check("ties_best_x_const", 32'(best_x), 100);
    check("ties_best_score_const", best_score, -1);
    @(posedge clk); #1;
    ramp();
    begin_strip(600);
    q.push_back(model(10, 600, 1));
    drive(10, 9, 0);
    check("early_done", 32'(done), 1);
    check("early_ready_low", 32'(score_ready), 0);
    check("early_len_err_const", 32'(len_err), 1);
    @(posedge clk); #1;
    check("early_ready_idle", 32'(score_ready), 0);
    begin_strip(600);
    q.push_back(model(625, 600, 1));
    drive(625, -1, 0);
    check("nolast_done", 32'(done), 1);
    score_valid = 1;
    score_data = 32'sd5000;
    check("nolast_626_refused", 32'(score_ready), 0);
    @(posedge clk); #1;
    check("nolast_626_idle", 32'(score_ready), 0);
    check("nolast_best_keep", best_score, 624);
    score_valid = 0;
    for (int i = 0; i < 640; i++) sc[i] = 2000;
    begin_strip(600);
    drive(50, -1, 0);
    ramp();
    sc[7] = 1000;
    begin_strip(600);
    check("abort_outputs_hold", 32'(best_x), 624);
    q.push_back(model(625, 600, 0));
    drive(625, 624, 0);
    check("abort_best_x_const", 32'(best_x), 7);
    check("abort_above_const", 32'(above_cnt), 26);
    @(posedge clk); #1;
    ramp();
    begin_strip(600);
    drive(40, -1, 1);
    #2 rst = 1;
    #1;
    check("arst_ready", 32'(score_ready), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_best_score", best_score, 0);
    check("arst_best_x", 32'(best_x), 0);
    check("arst_above", 32'(above_cnt), 0);
    check("arst_pf_le", {30'b0, peak_found, len_err}, 0);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    begin_strip(600);
    q.push_back(model(625, 600, 0));
    drive(625, 624, 2);
    check("gap_done", 32'(done), 1);
    check("gap_best_x_const", 32'(best_x), 624);
    repeat (3) @(posedge clk);
    #1 check("queue_empty", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
